// File: rtl/load_store_unit.sv
// Load/store stage: drives the data-memory req/ready bus, steers store lanes,
// extends load data and stalls the core until the access has completed.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned TW      = 8
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic        MEM_RD,
  input  logic        MEM_WR,
  input  logic [2:0]  FUNCT3,
  input  logic [31:0] ADDR,
  input  logic [31:0] STORE_DATA,
  output logic        D_REQ,
  output logic        D_WE,
  output logic [31:0] D_ADDR,
  output logic [31:0] D_WDATA,
  output logic [3:0]  D_BE,
  input  logic        D_READY,
  input  logic [31:0] D_RDATA,
  output logic [31:0] MEM_READ,
  output logic        STALL,
  output logic        ACC_FAULT,
  output logic        BUS_ERR
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  // Last counter value before abort; unused when TIMEOUT is 0 (wait forever).
  localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    be_q, be_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [31:0]   mem_read_q, mem_read_d;
  logic          fault_q, fault_d;
  logic          buserr_q, buserr_d;

  logic          request;
  logic          illegal;
  logic [3:0]    be_n;
  logic [31:0]   wdata_n;
  logic [7:0]    byte_sel;
  logic [15:0]   half_sel;
  logic [31:0]   load_val;

  assign request = MEM_RD | MEM_WR;

  // Classify the incoming request as illegal (conflicting, bad funct3 or misaligned).
  always_comb begin
    illegal = 1'b0;
    if (MEM_RD && MEM_WR)                                  illegal = 1'b1;
    else if (MEM_RD && (FUNCT3 == 3'b011 || FUNCT3[2:1] == 2'b11)) illegal = 1'b1;
    else if (MEM_WR && FUNCT3 >= 3'b011)                   illegal = 1'b1;
    else if (FUNCT3[1:0] == 2'b01 && ADDR[0])              illegal = 1'b1;
    else if (FUNCT3[1:0] == 2'b10 && ADDR[1:0] != 2'b00)   illegal = 1'b1;
  end

  // Store lane steering; loads request the full word with zero write data.
  always_comb begin
    be_n    = 4'b1111;
    wdata_n = '0;
    if (MEM_WR) begin
      case (FUNCT3[1:0])
        2'b00:   begin be_n = 4'b0001 << ADDR[1:0];             wdata_n = {4{STORE_DATA[7:0]}};  end
        2'b01:   begin be_n = ADDR[1] ? 4'b1100 : 4'b0011;      wdata_n = {2{STORE_DATA[15:0]}}; end
        default: begin be_n = 4'b1111;                          wdata_n = STORE_DATA;            end
      endcase
    end
  end

  // Pick the addressed byte/half from the returned word and extend it.
  always_comb begin
    case (off_q)
      2'd0:    byte_sel = D_RDATA[7:0];
      2'd1:    byte_sel = D_RDATA[15:8];
      2'd2:    byte_sel = D_RDATA[23:16];
      default: byte_sel = D_RDATA[31:24];
    endcase
    half_sel = off_q[1] ? D_RDATA[31:16] : D_RDATA[15:0];
    case (f3_q)
      3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_val = {24'b0, byte_sel};
      3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_val = {16'b0, half_sel};
      default: load_val = D_RDATA;
    endcase
  end

  // Next-state logic for the IDLE -> ACCESS -> DONE sequence.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    f3_d       = f3_q;
    off_d      = off_q;
    mem_read_d = mem_read_q;
    fault_d    = 1'b0;
    buserr_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (request && illegal) begin
          fault_d = 1'b1;
        end else if (request) begin
          we_d    = MEM_WR;
          addr_d  = {ADDR[31:2], 2'b00};
          wdata_d = wdata_n;
          be_d    = be_n;
          f3_d    = FUNCT3;
          off_d   = ADDR[1:0];
          cnt_d   = '0;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (D_READY) begin
          if (!we_q) mem_read_d = load_val;
          state_d = S_DONE;
        end else if (TIMEOUT != 0 && cnt_q == TO_LAST) begin
          // An aborted store leaves the load result untouched.
          if (!we_q) mem_read_d = '0;
          buserr_d = 1'b1;
          state_d  = S_DONE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with asynchronous clear.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      f3_q       <= '0;
      off_q      <= '0;
      mem_read_q <= '0;
      fault_q    <= 1'b0;
      buserr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      mem_read_q <= mem_read_d;
      fault_q    <= fault_d;
      buserr_q   <= buserr_d;
    end
  end

  assign D_REQ     = (state_q == S_ACCESS);
  assign D_WE      = we_q;
  assign D_ADDR    = addr_q;
  assign D_WDATA   = wdata_q;
  assign D_BE      = be_q;
  assign MEM_READ  = mem_read_q;
  assign ACC_FAULT = fault_q;
  assign BUS_ERR   = buserr_q;
  // Stall is forced low while reset is held so the core is never frozen in reset.
  assign STALL     = RSTN && ((state_q == S_ACCESS) ||
                              (state_q == S_IDLE && request && !illegal));

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Multi-cycle data-memory access stage for the RV32I core. It sits between the ALU and the write-back mux and drives the data-memory bus with a req/ready handshake. It performs byte/halfword lane steering and sign/zero extension, and delivers the loaded word on MEM_READ to the write-back mux. It stalls the core until the access completes and flags misaligned, illegal and timed-out accesses.

Parameters:
TIMEOUT, 255, max cycles to wait for D_READY before aborting; 0 = wait forever
TW, 8, width of the timeout counter; must satisfy TIMEOUT < 2^TW

Ports:
CLK  input  1  core clock; all state changes on rising edge
RSTN  input  1  asynchronous active-low reset
MEM_RD  input  1  current instruction is a load
MEM_WR  input  1  current instruction is a store
FUNCT3  input  3  instr[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU
ADDR  input  32  effective address (ALU_OUT)
STORE_DATA  input  32  rs2 value
D_REQ  output  1  bus request, held until accepted
D_WE  output  1  1 = write
D_ADDR  output  32  word-aligned address, {ADDR[31:2],2'b00}
D_WDATA  output  32  lane-replicated store data
D_BE  output  4  byte enables
D_READY  input  1  bus accepts/completes the access this cycle
D_RDATA  input  32  read word, valid when D_READY=1
MEM_READ  output  32  registered, extended load result to the write-back mux
STALL  output  1  core must hold PC and pipeline registers
ACC_FAULT  output  1  one-cycle pulse: misaligned or illegal access
BUS_ERR  output  1  one-cycle pulse: timeout abort

Behaviour:
- Reset (async, RSTN=0): state IDLE; D_REQ, D_WE, D_ADDR, D_WDATA, D_BE, MEM_READ, ACC_FAULT, BUS_ERR and the counter all 0. D_REQ drops immediately, including mid-access.
- States: IDLE, ACCESS, DONE.
- IDLE, request = MEM_RD|MEM_WR:
  - STALL = request AND the access is legal (combinational).
  - Legal access: latch the bus fields (D_ADDR, D_WE, D_BE, D_WDATA), FUNCT3 and ADDR[1:0]; go to ACCESS.
  - Illegal access: MEM_RD and MEM_WR both set; load FUNCT3 in {011,110,111}; store FUNCT3 >= 011; H/HU with ADDR[0]=1; W with ADDR[1:0]!=0.
  - On an illegal access: ACC_FAULT=1 next cycle for exactly one cycle, no bus access, STALL=0, MEM_READ unchanged, stay in IDLE.
- ACCESS:
  - D_REQ=1; STALL=1; all bus outputs stable until accepted.
  - The counter increments every cycle with D_READY=0.
  - D_READY=1: for a load, MEM_READ <= extract(D_RDATA). Drop D_REQ and go to DONE.
  - Counter reaches TIMEOUT (TIMEOUT != 0) with no D_READY: drop D_REQ, MEM_READ <= 0, BUS_ERR pulses one cycle, go to DONE.
- DONE:
  - STALL=0 for exactly one cycle so the core commits; the write-back mux samples MEM_READ.
  - The held request inputs are ignored (no relaunch); return to IDLE.
- Minimum latency: a load or store with D_READY already high costs 2 stall cycles (IDLE cycle plus ACCESS cycle); commit happens in DONE.
- Store lane steering:
  - SB: D_BE = 0001 << ADDR[1:0]; D_WDATA = {4{STORE_DATA[7:0]}}.
  - SH: D_BE = 0011 if ADDR[1]=0, else 1100; D_WDATA = {2{STORE_DATA[15:0]}}.
  - SW: D_BE = 1111; D_WDATA = STORE_DATA.
  - Loads drive D_BE = 1111 and D_WDATA = 0.
- Load extract:
  - Byte select: ADDR[1:0]. Half select: ADDR[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- MEM_READ holds its last value except on load completion, timeout or reset; stores never modify it.
- D_READY while not in ACCESS is ignored.

Test Plan:
- LB, ADDR=0x1003, D_RDATA=0x80AA5511, D_READY on the 1st ACCESS cycle -> D_ADDR=0x1000, D_BE=1111, MEM_READ=0xFFFFFF80, STALL high exactly 2 cycles, then low in DONE.
- LHU, ADDR=0x2002, D_RDATA=0xBEEF1234, D_READY delayed 3 cycles -> D_REQ held 4 cycles with stable outputs; MEM_READ=0x0000BEEF; STALL high 5 cycles.
- SB, ADDR=0x11, STORE_DATA=0x123456A5 -> D_WE=1, D_ADDR=0x10, D_BE=0010, D_WDATA=0xA5A5A5A5; MEM_READ unchanged.
- SH at ADDR=0x3 and LW at ADDR=0x6 -> ACC_FAULT pulses 1 cycle each; D_REQ never asserts; STALL=0.
- TIMEOUT=4, load with D_READY held low -> D_REQ drops after 4 cycles; BUS_ERR 1-cycle pulse; MEM_READ=0; returns to IDLE via DONE.
- RSTN low during ACCESS -> D_REQ, STALL and MEM_READ go to 0 immediately; after release, an SW with ADDR=0x40 and STORE_DATA=0xDEADBEEF completes normally with D_BE=1111.
